// File: rtl/fp_int_serial_feeder.sv
// Bit-serial transmit feeder: buffers {FP16 activation, packed weight, precision}
// operand pairs in a small FIFO and replays each as an MSB-first weight bit stream.
module fp_int_serial_feeder #(
    parameter int ACT_WIDTH     = 16,
    parameter int MAX_PRECISION = 8,
    parameter int DEPTH         = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ACT_WIDTH-1:0]     in_act,
    input  logic [MAX_PRECISION-1:0] in_w,
    input  logic [3:0]               in_precision,
    output logic [ACT_WIDTH-1:0]     out_act,
    output logic                     out_w,
    output logic                     out_valid,
    output logic                     out_last,
    output logic                     busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] MAXP = 4'(MAX_PRECISION);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [ACT_WIDTH-1:0]     act_mem_q  [DEPTH];
    logic [MAX_PRECISION-1:0] w_mem_q    [DEPTH];
    logic [3:0]               prec_mem_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [AW:0]              count_q, count_d;

    state_t                   state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic [MAX_PRECISION-1:0] sreg_q, sreg_d;
    logic [ACT_WIDTH-1:0]     out_act_q, out_act_d;
    logic                     out_w_q, out_w_d;
    logic                     out_valid_q, out_valid_d;
    logic                     out_last_q, out_last_d;

    logic                     push, pop, fifo_empty;
    logic [3:0]               prec_in;
    logic [MAX_PRECISION-1:0] shifted;

    // Zero or out-of-range precision means a full-width word.
    assign prec_in    = (in_precision == 4'd0 || in_precision > MAXP) ? MAXP : in_precision;
    assign in_ready   = (count_q != FULL);
    assign fifo_empty = (count_q == '0);
    assign push       = in_valid & in_ready;
    assign count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sreg_d      = sreg_q;
        out_act_d   = out_act_q;
        out_w_d     = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        pop         = 1'b0;
        shifted     = '0;
        if (state_q == SHIFT && cnt_q != 4'd0) begin
            cnt_d       = cnt_q - 4'd1;
            shifted     = sreg_q >> cnt_d;
            out_w_d     = shifted[0];
            out_valid_d = 1'b1;
            out_last_d  = (cnt_d == 4'd0);
        end else if (!fifo_empty) begin
            // Idle or finishing bit 0: pop the head so words stream without a gap.
            pop         = 1'b1;
            state_d     = SHIFT;
            sreg_d      = w_mem_q[rd_ptr_q];
            cnt_d       = prec_mem_q[rd_ptr_q] - 4'd1;
            out_act_d   = act_mem_q[rd_ptr_q];
            shifted     = w_mem_q[rd_ptr_q] >> cnt_d;
            out_w_d     = shifted[0];
            out_valid_d = 1'b1;
            out_last_d  = (cnt_d == 4'd0);
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_act_q   <= '0;
            out_w_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_act_q   <= out_act_d;
            out_w_q     <= out_w_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        sreg_q <= sreg_d;
        if (push) begin
            act_mem_q[wr_ptr_q]  <= in_act;
            w_mem_q[wr_ptr_q]    <= in_w;
            prec_mem_q[wr_ptr_q] <= prec_in;
        end
    end

    assign out_act   = out_act_q;
    assign out_w     = out_w_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = !fifo_empty || (state_q == SHIFT);
endmodule

// File: tb/tb_fp_int_serial_feeder.sv
// Self-checking bench for fp_int_serial_feeder: queue-based reference model plus
// directed literal sequences and a randomized traffic phase.
module tb_fp_int_serial_feeder;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_act = '0;
    logic [7:0]  in_w = '0;
    logic [3:0]  in_precision = '0;
    logic        in_ready, out_w, out_valid, out_last, busy;
    logic [15:0] out_act;

    always #5 clk = ~clk;

    fp_int_serial_feeder #(.ACT_WIDTH(16), .MAX_PRECISION(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .in_w(in_w), .in_precision(in_precision),
        .out_act(out_act), .out_w(out_w), .out_valid(out_valid),
        .out_last(out_last), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int stalls = 0;
    bit started = 0;

    typedef struct {logic [15:0] act; logic [7:0] w; int prec;} word_t;
    typedef struct {bit w; bit last; logic [15:0] act; int cyc;} obs_t;

    word_t mq[$];
    word_t cur, nw;
    int    idx;
    bit    active, mpush;
    logic [15:0] e_act = '0;
    bit    e_w, e_valid, e_last;
    obs_t  log_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int clamp(input logic [3:0] p);
        return (p == 0 || p > 8) ? 8 : int'(p);
    endfunction

    // Reference model: a word is a list of prec bits, MSB first; a new word is
    // taken from the queue only when nothing is showing or bit 0 was just shown.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            started = 1;
            mq.delete();
            active = 0; idx = 0;
            e_act = '0; e_w = 0; e_valid = 0; e_last = 0;
        end else begin
            mpush = in_valid && (mq.size() < DEPTH);
            nw.act = in_act; nw.w = in_w; nw.prec = clamp(in_precision);
            if (active && idx > 0) begin
                idx--;
            end else if (mq.size() > 0) begin
                cur = mq.pop_front();
                active = 1;
                idx = cur.prec - 1;
                e_act = cur.act;
            end else begin
                active = 0;
            end
            if (mpush) mq.push_back(nw);
            e_valid = active;
            e_w     = active ? cur.w[idx] : 1'b0;
            e_last  = active && (idx == 0);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("in_ready",  in_ready,  mq.size() != DEPTH);
            check("busy",      busy,      (mq.size() != 0) || active);
            check("out_valid", out_valid, e_valid);
            check("out_w",     out_w,     e_w);
            check("out_last",  out_last,  e_last);
            check("out_act",   out_act,   e_act);
            if (out_valid === 1'b1) begin
                obs_t o;
                o.w = out_w; o.last = out_last; o.act = out_act; o.cyc = cyc;
                log_q.push_back(o);
            end
        end
    end

    task automatic push_word(input logic [15:0] a, input logic [7:0] w, input logic [3:0] p);
        int n = 0;
        in_valid = 1; in_act = a; in_w = w; in_precision = p;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n > 0) stalls++;
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL push_timeout: in_ready stayed %0b, required 1", in_ready);
        end
        @(negedge clk);
        acc_cyc = cyc;
    endtask

    task automatic drain();
        int n = 0;
        in_valid = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            checks++; errors++;
            $display("FAIL drain_timeout: busy stayed %0b, required 0", busy);
        end
        @(negedge clk);
    endtask

    // Compare the captured stream to literal bits/last flags (MSB = first bit).
    task automatic check_log(input string name, input logic [31:0] bits, input int n,
                             input logic [31:0] lastm, input int first, input int gap_at);
        check({name, "_len"}, log_q.size(), n);
        if (log_q.size() == n) begin
            for (int i = 0; i < n; i++) begin
                check($sformatf("%s_w%0d", name, i), log_q[i].w, bits[n-1-i]);
                check($sformatf("%s_last%0d", name, i), log_q[i].last, lastm[n-1-i]);
                check($sformatf("%s_cyc%0d", name, i), log_q[i].cyc,
                      first + i + ((gap_at >= 0 && i >= gap_at) ? 1 : 0));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        rst = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        check("reset_valid", out_valid, 0);
        check("reset_busy",  busy, 0);
        check("reset_ready", in_ready, 1);
        check("reset_act",   out_act, 0);

        // Single word: bits 1,0,1,1, first bit one cycle after the accepting edge.
        log_q.delete();
        push_word(16'h3C00, 8'h0B, 4'd4);
        a = acc_cyc;
        drain();
        check_log("single", 32'b1011, 4, 32'b0001, a + 1, -1);
        foreach (log_q[i]) check($sformatf("single_act%0d", i), log_q[i].act, 16'h3C00);

        // Four back-to-back words: 16 contiguous bits with backpressure.
        log_q.delete();
        stalls = 0;
        push_word(16'h1111, 8'h0A, 4'd4);
        a = acc_cyc;
        push_word(16'h2222, 8'h05, 4'd4);
        push_word(16'h3333, 8'h0F, 4'd4);
        push_word(16'h4444, 8'h09, 4'd4);
        drain();
        check_log("burst", 32'hA5F9, 16, 32'h1111, a + 1, -1);
        if (log_q.size() == 16)
            for (int i = 0; i < 16; i += 4)
                check($sformatf("burst_act%0d", i), log_q[i].act, 16'h1111 * (i / 4 + 1));
        check("burst_stalled", stalls > 0, 1);

        // Mixed precision, contiguous.
        log_q.delete();
        push_word(16'hAAAA, 8'h02, 4'd2);
        a = acc_cyc;
        push_word(16'hBBBB, 8'hA5, 4'd8);
        drain();
        check_log("mixed", 32'b1010100101, 10, 32'b0100000001, a + 1, -1);

        // Clamp and masking cases.
        log_q.delete(); push_word(16'h0001, 8'h81, 4'd0); a = acc_cyc; drain();
        check_log("prec0", 32'h81, 8, 32'h01, a + 1, -1);
        log_q.delete(); push_word(16'h0002, 8'h3C, 4'd9); a = acc_cyc; drain();
        check_log("prec9", 32'h3C, 8, 32'h01, a + 1, -1);
        log_q.delete(); push_word(16'h0003, 8'hFA, 4'd3); a = acc_cyc; drain();
        check_log("prec3", 32'b010, 3, 32'b001, a + 1, -1);
        log_q.delete(); push_word(16'h0004, 8'h01, 4'd1); a = acc_cyc; drain();
        check_log("prec1", 32'b1, 1, 32'b1, a + 1, -1);

        // Reset after two bits of a word with another queued.
        push_word(16'h5555, 8'hF0, 4'd4);
        push_word(16'h6666, 8'hFF, 4'd4);
        in_valid = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("midrst_valid", out_valid, 0);
        check("midrst_busy",  busy, 0);
        check("midrst_ready", in_ready, 1);
        rst = 1;
        log_q.delete();
        push_word(16'h7777, 8'h0D, 4'd4);
        a = acc_cyc;
        drain();
        check_log("postrst", 32'b1101, 4, 32'b0001, a + 1, -1);
        if (log_q.size() > 0) check("postrst_act", log_q[0].act, 16'h7777);

        // Push landing on the last-bit edge: exactly one empty cycle.
        log_q.delete();
        push_word(16'hC0C0, 8'h03, 4'd2);
        a = acc_cyc;
        in_valid = 0;
        repeat (2) @(negedge clk);
        push_word(16'hD0D0, 8'h05, 4'd3);
        drain();
        check_log("gap", 32'b11101, 5, 32'b01001, a + 1, 2);

        // Randomized traffic with occasional reset, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            in_valid     = ($urandom_range(0, 2) != 0);
            in_act       = 16'($urandom);
            in_w         = 8'($urandom);
            in_precision = 4'($urandom_range(0, 15));
            rst          = ($urandom_range(0, 199) != 0);
            @(negedge clk);
        end
        rst = 1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fp_int_serial_feeder.md
Name: fp_int_serial_feeder

Overview:
- Transmit side of the bit-serial FP16 x INT-weight interface. Accepts whole operand pairs (FP16 activation plus a packed integer weight of per-word precision) over a valid/ready handshake and buffers them in a small FIFO.
- Replays each pair as the bit-serial stream the multiplier expects: act held constant, one weight bit per cycle MSB-first, valid high for exactly `precision` cycles.
- Sits between the operand SRAM/loader and the multiplier array's act/w/valid inputs.

Parameters:
- ACT_WIDTH, 16, activation width (FP16: 1 sign, 5 exponent, 10 mantissa).
- MAX_PRECISION, 8, maximum weight bits per word; also the width of in_w.
- DEPTH, 2, FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst  input  1  reset, synchronous, active-low.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  FIFO can accept. Equals !full, combinational from the occupancy count.
- in_act  input  ACT_WIDTH  FP16 activation.
- in_w  input  MAX_PRECISION  weight word, LSB-aligned. Bits at and above precision are ignored.
- in_precision  input  4  weight bit count for this word, captured with the word.
- out_act  output  ACT_WIDTH  activation of the word being serialized, registered.
- out_w  output  1  current weight bit, registered.
- out_valid  output  1  high while a weight bit is presented, registered.
- out_last  output  1  high on the final bit of each word, registered.
- busy  output  1  FIFO non-empty or serializer active.

Behaviour:
- Reset (rst=0 at a rising edge):
  - FIFO pointers and count are cleared and any in-flight word is dropped.
  - out_act=0, out_w=0, out_valid=0, out_last=0, busy=0, state=IDLE.
  - in_ready=1 from the cycle after reset. This applies equally when reset is asserted mid-word.
- Push:
  - Occurs when in_valid & in_ready at a rising edge.
  - Stores {in_act, in_w, prec}. prec = in_precision clamped: 0 or >MAX_PRECISION gives MAX_PRECISION; otherwise it is in_precision.
  - in_valid while in_ready=0 has no effect. The upstream holds its data.
- Serializer FSM, states IDLE and SHIFT:
  - IDLE with FIFO non-empty: pop the head, load shift register and out_act, set bit counter to prec-1, present bit prec-1 on out_w, set out_valid=1, go to SHIFT. All of this takes effect at the same edge.
  - IDLE with FIFO empty: out_valid=0, out_w=0, out_last=0. out_act holds its last value.
  - SHIFT: each edge decrements the counter and presents the next lower bit.
  - out_last=1 on the cycle that presents bit 0, including the single cycle of a prec=1 word.
  - Leaving the bit-0 cycle with the FIFO non-empty: pop the next word at that edge. out_valid stays high with no gap and out_act changes at the word boundary.
  - Leaving the bit-0 cycle with the FIFO empty: go to IDLE and drop out_valid.
- Latency: a word pushed into an empty FIFO while IDLE presents its first bit in the cycle after the push edge plus one. The push edge writes the FIFO; the next edge pops it.
- Throughput: one weight bit per cycle sustained. No bubbles between words while the FIFO stays non-empty.
- Simultaneous push and pop:
  - Allowed in the same edge. Occupancy is unchanged.
  - When the FIFO is full, in_ready=0 even if a pop occurs that edge; there is no pass-through.
  - A push into the empty FIFO in the same cycle the serializer finishes its last bit is not bypassed. The word pops at the next edge, so out_valid shows a one-cycle gap.
- Pointers wrap modulo DEPTH. Occupancy count width is log2(DEPTH)+1.
- busy = (count!=0) | (state==SHIFT).
- Precision is per word; mixed precisions may be interleaved freely.

Test Plan:
- Single word, prec=4, in_w=8'h0B, in_act=16'h3C00 → out_valid high exactly 4 cycles starting 2 cycles after the push. out_w=1,0,1,1. out_act=3C00 throughout. out_last only on the 4th cycle.
- Four words back-to-back, prec=4, in_valid held high → 16 contiguous out_valid cycles with out_act changing every 4. in_ready drops to 0 once 2 entries are buffered and recovers as words pop.
- Mixed precision: {prec=2, w=2'b10} then {prec=8, w=8'hA5} → out_w 1,0,1,0,1,0,0,1,0,1 contiguous. out_last on cycles 2 and 10.
- Clamp and masking:
  - prec=0, w=8'h81 → 8 bits 1,0,0,0,0,0,0,1.
  - prec=9 → treated as 8.
  - prec=3, w=8'hFA → 0,1,0.
  - prec=1, w=1 → a single cycle with out_valid=out_last=1.
- Reset asserted after 2 of 4 bits with 1 word queued → next cycle out_valid=0, busy=0, in_ready=1. A subsequent push streams normally with no residue of the dropped words.
- Push arriving exactly on the last bit cycle of an otherwise empty stream → exactly one-cycle out_valid gap, then the new word streams correctly.
